// File: rtl/fifo_async_gray.sv
`default_nettype none
// ============================================================================
// Module   : fifo_async_gray
// Purpose  : Dual-clock FIFO. Gray-coded pointers cross the clock domains and
//            the read port is show-ahead. Defining FIFO_ASYNC_GRAY_LEVEL_EN
//            adds the level outputs and the almost_full/almost_empty flags.
// Revision : 1.0  initial release
// ============================================================================
module fifo_async_gray #(
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_SIZE   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = (2**DATA_SIZE) - 2,
  parameter int AE_LEVEL    = 2
) (
  input  logic                  arst_n,
  input  logic                  clk_i,
  input  logic                  clk_o,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_SIZE:0]    wr_level,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic [DATA_SIZE:0]    rd_level,
  output logic                  almost_empty
);

  localparam int                 DEPTH   = 2**DATA_SIZE;
  localparam logic [DATA_SIZE:0] c_DEPTH = (DATA_SIZE+1)'(DEPTH);
  localparam logic [DATA_SIZE:0] c_ONE   = (DATA_SIZE+1)'(1);

  if (DATA_WIDTH < 1 || DATA_SIZE < 1 || SYNC_STAGES < 2 ||
      AF_LEVEL < 0 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_param_chk
    $error("fifo_async_gray: illegal parameter combination");
  end

  function automatic logic [DATA_SIZE:0] bin2gray(input logic [DATA_SIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [DATA_SIZE:0] gray2bin(input logic [DATA_SIZE:0] g);
    logic [DATA_SIZE:0] b;
    b[DATA_SIZE] = g[DATA_SIZE];
    for (int i = DATA_SIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // ---------------------------------------------------------------- write side
  logic [1:0]                        wr_rst_q;
  logic [DATA_SIZE:0]                wr_bin_q;
  logic [DATA_SIZE:0]                wr_bin_d;
  logic [DATA_SIZE:0]                wr_gray_q;
  logic [SYNC_STAGES-1:0][DATA_SIZE:0] rd_gray_sync_q;
  logic [DATA_SIZE:0]                w_rd_bin_wr;
  logic                              w_full;
  logic                              w_wr_en;

  // Reset is asserted asynchronously but released only after two local edges.
  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) wr_rst_q <= '0;
    else         wr_rst_q <= {wr_rst_q[0], 1'b1};
  end

  assign w_rd_bin_wr   = gray2bin(rd_gray_sync_q[SYNC_STAGES-1]);
  assign w_full        = (wr_bin_q - w_rd_bin_wr) == c_DEPTH;
  assign data_in_ready = wr_rst_q[1] & ~w_full;
  assign w_wr_en       = data_in_valid & data_in_ready;
  assign wr_bin_d      = wr_bin_q + (w_wr_en ? c_ONE : '0);

  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      wr_bin_q       <= '0;
      wr_gray_q      <= '0;
      rd_gray_sync_q <= '0;
    end else begin
      wr_bin_q       <= wr_bin_d;
      wr_gray_q      <= bin2gray(wr_bin_d);
      rd_gray_sync_q <= {rd_gray_sync_q[SYNC_STAGES-2:0], rd_gray_q};
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_en) mem_q[wr_bin_q[DATA_SIZE-1:0]] <= data_in;
  end

  // ----------------------------------------------------------------- read side
  logic [1:0]                        rd_rst_q;
  logic [DATA_SIZE:0]                rd_bin_q;
  logic [DATA_SIZE:0]                rd_bin_d;
  logic [DATA_SIZE:0]                rd_gray_q;
  logic [SYNC_STAGES-1:0][DATA_SIZE:0] wr_gray_sync_q;
  logic                              w_rd_en;

  always_ff @(posedge clk_o or negedge arst_n) begin
    if (!arst_n) rd_rst_q <= '0;
    else         rd_rst_q <= {rd_rst_q[0], 1'b1};
  end

  assign data_out_valid = rd_rst_q[1] & (wr_gray_sync_q[SYNC_STAGES-1] != rd_gray_q);
  assign w_rd_en        = data_out_valid & data_out_ready;
  assign rd_bin_d       = rd_bin_q + (w_rd_en ? c_ONE : '0);
  assign data_out       = mem_q[rd_bin_q[DATA_SIZE-1:0]];

  always_ff @(posedge clk_o or negedge arst_n) begin
    if (!arst_n) begin
      rd_bin_q       <= '0;
      rd_gray_q      <= '0;
      wr_gray_sync_q <= '0;
    end else begin
      rd_bin_q       <= rd_bin_d;
      rd_gray_q      <= bin2gray(rd_bin_d);
      wr_gray_sync_q <= {wr_gray_sync_q[SYNC_STAGES-2:0], wr_gray_q};
    end
  end

  // -------------------------------------------------------- occupancy levels
`ifdef FIFO_ASYNC_GRAY_LEVEL_EN
  localparam logic [DATA_SIZE:0] c_AF_LEVEL = (DATA_SIZE+1)'(AF_LEVEL);
  localparam logic [DATA_SIZE:0] c_AE_LEVEL = (DATA_SIZE+1)'(AE_LEVEL);

  logic [DATA_SIZE:0] wr_level_q;
  logic [DATA_SIZE:0] rd_level_q;
  logic [DATA_SIZE:0] w_wr_bin_rd;

  assign w_wr_bin_rd = gray2bin(wr_gray_sync_q[SYNC_STAGES-1]);

  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) wr_level_q <= '0;
    else         wr_level_q <= wr_bin_q - w_rd_bin_wr;
  end

  always_ff @(posedge clk_o or negedge arst_n) begin
    if (!arst_n) rd_level_q <= '0;
    else         rd_level_q <= w_wr_bin_rd - rd_bin_q;
  end

  assign wr_level     = wr_level_q;
  assign rd_level     = rd_level_q;
  assign almost_full  = wr_level_q >= c_AF_LEVEL;
  assign almost_empty = rd_level_q <= c_AE_LEVEL;
`else
  assign wr_level     = '0;
  assign rd_level     = '0;
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_async_gray.sv
`default_nettype none
// tb_fifo_async_gray: directed checks on a depth-4 and a depth-16 instance,
// plus a random-traffic scoreboard run at 3:1 and 1:3 clock ratios.
module tb_fifo_async_gray;

`ifdef FIFO_ASYNC_GRAY_LEVEL_EN
  localparam logic c_LVL = 1'b1;
`else
  localparam logic c_LVL = 1'b0;
`endif

  int   w_half = 10;
  int   r_half = 27;
  logic clk_i  = 1'b0;
  logic clk_o  = 1'b0;
  logic arst_n = 1'b0;

  initial forever #(w_half) clk_i = ~clk_i;
  initial forever #(r_half) clk_o = ~clk_o;

  logic [7:0] a_din = '0, b_din = '0;
  logic       a_vin = 0, b_vin = 0, a_rdout = 0, b_rdout = 0;
  logic       a_rdy, b_rdy, a_vout, b_vout, a_af, b_af, a_ae, b_ae;
  logic [7:0] a_dout, b_dout;
  logic [2:0] a_wl, a_rl;
  logic [4:0] b_wl, b_rl;

  fifo_async_gray #(.DATA_WIDTH(8), .DATA_SIZE(2), .SYNC_STAGES(2),
                    .AF_LEVEL(2), .AE_LEVEL(1)) u_dut_a (
    .arst_n(arst_n), .clk_i(clk_i), .clk_o(clk_o),
    .data_in(a_din), .data_in_valid(a_vin), .data_in_ready(a_rdy),
    .wr_level(a_wl), .almost_full(a_af),
    .data_out(a_dout), .data_out_valid(a_vout), .data_out_ready(a_rdout),
    .rd_level(a_rl), .almost_empty(a_ae));

  fifo_async_gray #(.DATA_WIDTH(8), .DATA_SIZE(4)) u_dut_b (
    .arst_n(arst_n), .clk_i(clk_i), .clk_o(clk_o),
    .data_in(b_din), .data_in_valid(b_vin), .data_in_ready(b_rdy),
    .wr_level(b_wl), .almost_full(b_af),
    .data_out(b_dout), .data_out_valid(b_vout), .data_out_ready(b_rdout),
    .rd_level(b_rl), .almost_empty(b_ae));

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wr_a(input logic [7:0] d);
    @(negedge clk_i); a_din = d; a_vin = 1'b1;
    @(negedge clk_i); a_vin = 1'b0;
  endtask

  task automatic wr_b(input logic [7:0] d);
    @(negedge clk_i); b_din = d; b_vin = 1'b1;
    @(negedge clk_i); b_vin = 1'b0;
  endtask

  task automatic rd_a(input logic [7:0] exp, input string tag);
    int n = 0;
    @(negedge clk_o);
    while (!a_vout && n < 20) begin @(negedge clk_o); n++; end
    check({tag, "_v"}, a_vout, 1);
    check(tag, a_dout, exp);
    a_rdout = 1'b1;
    @(negedge clk_o); a_rdout = 1'b0;
  endtask

  task automatic rd_b(input logic [7:0] exp, input string tag);
    int n = 0;
    @(negedge clk_o);
    while (!b_vout && n < 20) begin @(negedge clk_o); n++; end
    check({tag, "_v"}, b_vout, 1);
    check(tag, b_dout, exp);
    b_rdout = 1'b1;
    @(negedge clk_o); b_rdout = 1'b0;
  endtask

  task automatic release_rst();
    @(negedge clk_i); #3 arst_n = 1'b1;
    @(posedge clk_i); #1 check("rel_edge1_rdy", a_rdy, 0);
    @(posedge clk_i); #1 check("rel_edge2_rdy", a_rdy, 1);
    check("rel_edge2_rdy_b", b_rdy, 1);
  endtask

  // Random traffic scoreboard on instance A
  logic [7:0] words [1000];
  int wi = 0;
  int ri = 0;

  task automatic run_phase(input int hi);
    fork
      begin : producer
        int   cyc  = 0;
        logic seen = 1'b0;
        while (wi < hi && cyc < 20000) begin
          @(negedge clk_i); cyc++;
          if (a_vin && seen) wi++;
          seen = a_rdy;
          if (wi < hi && $urandom_range(0, 3) != 0) begin
            a_vin = 1'b1; a_din = words[wi];
          end else a_vin = 1'b0;
        end
        a_vin = 1'b0;
      end
      begin : consumer
        int         cyc = 0;
        logic       vs  = 1'b0;
        logic [7:0] ds  = '0;
        while (ri < hi && cyc < 20000) begin
          @(negedge clk_o); cyc++;
          if (a_rdout && vs) begin
            check("sb_data", ds, words[ri]);
            ri++;
          end
          vs = a_vout; ds = a_dout;
          a_rdout = (ri < hi) && ($urandom_range(0, 2) != 0);
        end
        a_rdout = 1'b0;
      end
    join
    check("sb_wr_count", wi, hi);
    check("sb_rd_count", ri, hi);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1000; i++) words[i] = 8'($urandom);

    // Reset values
    repeat (3) @(negedge clk_i);
    check("rst_a_rdy", a_rdy, 0);
    check("rst_a_vout", a_vout, 0);
    check("rst_b_rdy", b_rdy, 0);
    check("rst_b_vout", b_vout, 0);
    check("rst_b_wl", b_wl, 0);
    check("rst_b_rl", b_rl, 0);
    check("rst_b_af", b_af, 0);
    check("rst_b_ae", b_ae, c_LVL);
    release_rst();

    // Fill depth-4 FIFO, fifth write must be dropped
    for (int i = 1; i <= 4; i++) wr_a(8'(i));
    @(negedge clk_i); check("a_full_rdy", a_rdy, 0);
    wr_a(8'h05);
    @(negedge clk_o);
    check("a_rd1_v", a_vout, 1);
    check("a_rd1", a_dout, 8'h01);
    a_rdout = 1'b1;
    @(posedge clk_o); #1 a_rdout = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 check("a_rdy_after_pop", a_rdy, 1);
    rd_a(8'h02, "a_rd2");
    rd_a(8'h03, "a_rd3");
    rd_a(8'h04, "a_rd4");
    check("a_empty", a_vout, 0);
    repeat (4) @(negedge clk_o);
    check("a_no_fifth", a_vout, 0);

    // Single write latency into empty FIFO
    @(negedge clk_i); a_din = 8'hA5; a_vin = 1'b1;
    @(posedge clk_i); #1 a_vin = 1'b0;
    repeat (3) @(posedge clk_o);
    #1 check("a_lat_v", a_vout, 1);
    check("a_lat_d", a_dout, 8'hA5);
    rd_a(8'hA5, "a_lat_pop");
    check("a_lat_empty", a_vout, 0);

    // Levels and almost flags on depth-16 instance
    for (int i = 0; i < 13; i++) wr_b(8'(8'h10 + i));
    repeat (4) @(negedge clk_i);
    check("b_wl13", b_wl, c_LVL ? 13 : 0);
    check("b_af13", b_af, 0);
    wr_b(8'h1D);
    repeat (4) @(negedge clk_i);
    check("b_wl14", b_wl, c_LVL ? 14 : 0);
    check("b_af14", b_af, c_LVL);
    repeat (6) @(negedge clk_o);
    check("b_rl14", b_rl, c_LVL ? 14 : 0);
    check("b_ae14", b_ae, 0);
    for (int i = 0; i < 11; i++) rd_b(8'(8'h10 + i), "b_drain");
    repeat (3) @(negedge clk_o);
    check("b_rl3", b_rl, c_LVL ? 3 : 0);
    check("b_ae3", b_ae, 0);
    rd_b(8'h1B, "b_drain");
    repeat (3) @(negedge clk_o);
    check("b_rl2", b_rl, c_LVL ? 2 : 0);
    check("b_ae2", b_ae, c_LVL);
    rd_b(8'h1C, "b_drain");
    rd_b(8'h1D, "b_drain");
    check("b_empty", b_vout, 0);

    // Reset with words queued
    for (int i = 0; i < 5; i++) wr_b(8'(8'h40 + i));
    repeat (6) @(negedge clk_o);
    check("b_pre_rst_v", b_vout, 1);
    arst_n = 1'b0;
    #1 check("b_mid_rst_v", b_vout, 0);
    check("b_mid_rst_rdy", b_rdy, 0);
    check("b_mid_rst_rl", b_rl, 0);
    repeat (3) @(negedge clk_i);
    release_rst();
    repeat (4) @(negedge clk_o);
    check("b_post_rst_v", b_vout, 0);
    wr_b(8'h3C);
    rd_b(8'h3C, "b_first_after_rst");
    check("b_post_rst_empty", b_vout, 0);

    // Random traffic, write clock 3x then 1/3x the read clock
    w_half = 9;  r_half = 27;
    run_phase(500);
    w_half = 27; r_half = 9;
    run_phase(1000);
    repeat (8) @(negedge clk_o);
    check("sb_drained", a_vout, 0);
    check("sb_wraps_ge60", (ri / 8) >= 60, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_async_gray.md
FIFO_ASYNC_GRAY -- requirements
Module: fifo_async_gray

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload width in bits (>=1).
REQ-002 SHALL have parameter DATA_SIZE, default 4: log2 of depth; DEPTH = 2**DATA_SIZE (DATA_SIZE >= 1).
REQ-003 SHALL have parameter SYNC_STAGES, default 2: flops per gray-pointer synchronizer (>=2).
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-2: almost_full asserts when write-side level >= AF_LEVEL.
REQ-005 SHALL have parameter AE_LEVEL, default 2: almost_empty asserts when read-side level <= AE_LEVEL.
REQ-006 SHALL have port arst_n  input  1  reset, asynchronous, active-low, common to both domains.
REQ-007 SHALL have port clk_i  input  1  write-domain clock.
REQ-008 SHALL have port clk_o  input  1  read-domain clock, unrelated in phase and frequency to clk_i.
REQ-009 SHALL have port data_in  input  DATA_WIDTH  write payload (clk_i).
REQ-010 SHALL have port data_in_valid  input  1  write request (clk_i).
REQ-011 SHALL have port data_in_ready  output  1  space available (clk_i).
REQ-012 SHALL have port wr_level  output  DATA_SIZE+1  write-side occupancy estimate (clk_i).
REQ-013 SHALL have port almost_full  output  1  wr_level >= AF_LEVEL (clk_i).
REQ-014 SHALL have port data_out  output  DATA_WIDTH  head-of-queue payload (clk_o).
REQ-015 SHALL have port data_out_valid  output  1  data available (clk_o).
REQ-016 SHALL have port data_out_ready  input  1  consumer accept (clk_o).
REQ-017 SHALL have port rd_level  output  DATA_SIZE+1  read-side occupancy estimate (clk_o).
REQ-018 SHALL have port almost_empty  output  1  rd_level <= AE_LEVEL (clk_o).

Function
REQ-019 SHALL keep DATA_SIZE+1-bit binary and gray write/read pointers, each registered in its own domain.
REQ-020 SHALL cross only gray pointers, each through a SYNC_STAGES-flop synchronizer clocked by the destination clock.
REQ-021 SHALL accept a write on a clk_i edge iff data_in_valid & data_in_ready; write memory at wr_bin[DATA_SIZE-1:0], wr_bin+1 mod 2**(DATA_SIZE+1).
REQ-022 SHALL pop on a clk_o edge iff data_out_valid & data_out_ready; rd_bin+1 mod 2**(DATA_SIZE+1).
REQ-023 SHALL drive data_in_ready = 0 exactly when wr_bin - (synced rd, converted to binary) == DEPTH (full; pessimistic).
REQ-024 SHALL drive data_out_valid = 0 exactly when synced wr gray == rd gray (empty; pessimistic).
REQ-025 SHALL present data_out = mem[rd_bin[DATA_SIZE-1:0]] combinationally (show-ahead); data_out is don't-care while data_out_valid = 0.
REQ-026 SHALL ignore data_in_valid while full and data_out_ready while empty: no pointer, level or memory change.
REQ-027 SHALL assert data_out_valid no later than SYNC_STAGES+1 clk_o rising edges after the clk_i edge accepting a write into an empty FIFO.
REQ-028 SHALL reassert data_in_ready no later than SYNC_STAGES+1 clk_i rising edges after the clk_o edge popping from a full FIFO.
REQ-029 SHALL handle pointer wrap with the extra MSB: full vs empty distinguished at every multiple of DEPTH.
REQ-030 SHALL allow simultaneous write and read in the same or overlapping cycles with no loss, duplication or reordering.
REQ-031 SHALL sustain one write per clk_i cycle and one read per clk_o cycle when neither full nor empty.

Reset
REQ-032 SHALL clear all pointers, synchronizers and level registers on arst_n low, asynchronously, in both domains.
REQ-033 SHALL drive during reset: data_in_ready = 0, data_out_valid = 0, wr_level = 0, rd_level = 0, almost_full = 0, almost_empty = 1 (0 if level logic absent); memory is not reset.
REQ-034 SHALL release reset in each domain via an internal 2-flop reset synchronizer; data_in_ready rises on the 2nd clk_i edge after arst_n rises.
REQ-035 SHALL discard all contents on reset mid-operation; first post-reset read returns the first post-reset write.

Configuration
REQ-036 SHALL, with FIFO_ASYNC_GRAY_LEVEL_EN defined, compute wr_level = wr_bin - synced rd_bin and rd_level = synced wr_bin - rd_bin, registered, plus almost_full/almost_empty from them.
REQ-037 SHALL, without FIFO_ASYNC_GRAY_LEVEL_EN, tie wr_level, rd_level, almost_full, almost_empty to 0 and omit their logic; all other behaviour identical.

Verification
REQ-038 SHALL cover: DATA_SIZE=2, clk_i 100 MHz, clk_o 37 MHz, write 0x01..0x04, no reads -> data_in_ready=0 after 4th; 5th write ignored; reads return 0x01..0x04 in order.
REQ-039 SHALL cover: write single 0xA5 into empty FIFO -> data_out_valid high within 3 clk_o edges (SYNC_STAGES=2), data_out=0xA5.
REQ-040 SHALL cover: 1000 random words, clk_i 3x clk_o then 1/3x, random valid/ready -> scoreboard exact order, no loss, pointers wrapped >= 60 times.
REQ-041 SHALL cover: DEPTH=16, LEVEL_EN defined, 14 writes -> almost_full=1, wr_level=14; drain to 2 -> almost_empty=1, rd_level=2.
REQ-042 SHALL cover: arst_n pulsed low with 5 words queued -> data_out_valid=0 immediately; next write 0x3C read back as first word.
